// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with run-time pattern load, overlap select and saturating match counter.
// detect is combinational in the cycle the final bit is presented; no backpressure, bits arrive under din_valid.
module seq_detect_param #(
    parameter int                 PAT_LEN   = 4,
    parameter int                 CNT_W     = 8,
    parameter logic [PAT_LEN-1:0] PAT_RESET = PAT_LEN'(4'b1010)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din_valid,
    input  logic               din,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               overlap_en,
    input  logic               count_clr,
    output logic               detect,
    output logic [CNT_W-1:0]   match_count
);

    localparam int                FILL_W   = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] pat_r;
    logic [PAT_LEN-2:0] hist;
    logic [PAT_LEN-2:0] hist_shift;
    logic [FILL_W-1:0]  fill;
    logic               accept;
    logic               match;

    assign accept = din_valid & ~pat_load & ~reset;
    assign match  = accept && (fill == FILL_MAX) && ({hist, din} == pat_r);
    assign detect = match;

    // With a 2-bit pattern the history is a single bit, so there is nothing to shift through.
    generate
        if (PAT_LEN == 2) begin : g_hist_one
            assign hist_shift = din;
        end else begin : g_hist_shift
            assign hist_shift = {hist[PAT_LEN-3:0], din};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r <= PAT_RESET;
            hist  <= '0;
            fill  <= '0;
        end else if (pat_load) begin
            pat_r <= pat_in;
            hist  <= '0;
            fill  <= '0;
        end else if (accept) begin
            if (match && !overlap_en) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= hist_shift;
                if (fill != FILL_MAX)
                    fill <= fill + FILL_W'(1);
            end
        end
    end

    // Clear wins over a simultaneous detect; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset)
            match_count <= '0;
        else if (count_clr)
            match_count <= '0;
        else if (match && !(&match_count))
            match_count <= match_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default build plus a 2-bit counter build sharing the same stimulus.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       din_valid;
    logic       din;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       overlap_en;
    logic       count_clr;
    logic       detect;
    logic [7:0] match_count;
    logic       detect_sat;
    logic [1:0] match_count_sat;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .din        (din),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .overlap_en (overlap_en),
        .count_clr  (count_clr),
        .detect     (detect),
        .match_count(match_count)
    );

    seq_detect_param #(.CNT_W(2)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .din        (din),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .overlap_en (overlap_en),
        .count_clr  (count_clr),
        .detect     (detect_sat),
        .match_count(match_count_sat)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; presents one cycle of input, checks detect mid-cycle, returns after the next edge.
    task automatic bit_in(input logic v, input logic b, input logic exp_det, input string tag);
        din_valid = v;
        din       = b;
        @(negedge clk);
        check_val(tag, {31'd0, detect}, {31'd0, exp_det});
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    // Sends n accepted bits, MSB first; exp carries the expected detect per bit in the same order.
    task automatic send(input logic [7:0] bits, input int n, input logic [7:0] exp, input string tag);
        logic [7:0] b;
        logic [7:0] e;
        b = bits;
        e = exp;
        for (int i = 0; i < n; i++)
            bit_in(1'b1, b[n-1-i], e[n-1-i], $sformatf("%s_bit%0d", tag, i + 1));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        din_valid = 1'b0;
        pat_load  = 1'b0;
        count_clr = 1'b0;
        @(negedge clk);
        check_val("rst_detect", {31'd0, detect}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        din_valid  = 1'b0;
        din        = 1'b0;
        pat_load   = 1'b0;
        pat_in     = 4'b0000;
        overlap_en = 1'b0;
        count_clr  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        check_val("rst_count", {24'd0, match_count}, 32'd0);
        check_val("rst_count_sat", {30'd0, match_count_sat}, 32'd0);

        // Non-overlapping 1010 on 101010: only bit 4 hits.
        overlap_en = 1'b0;
        send(8'b0010_1010, 6, 8'b0000_0100, "t1");
        check_val("t1_count", {24'd0, match_count}, 32'd1);

        // Overlapping: bits 4 and 6 hit.
        do_reset();
        overlap_en = 1'b1;
        send(8'b0010_1010, 6, 8'b0000_0101, "t2");
        check_val("t2_count", {24'd0, match_count}, 32'd2);

        // Invalid cycles (din=1 on the wire) must not break the partial match.
        do_reset();
        overlap_en = 1'b0;
        send(8'b0000_0010, 2, 8'b0000_0000, "t3a");
        for (int i = 0; i < 3; i++)
            bit_in(1'b0, 1'b1, 1'b0, $sformatf("t3_gap%0d", i));
        send(8'b0000_0010, 2, 8'b0000_0001, "t3b");
        check_val("t3_count", {24'd0, match_count}, 32'd1);

        // Load 1101 on the cycle that would complete 1010; that bit is dropped.
        send(8'b0000_0101, 3, 8'b0000_0000, "t4a");
        pat_load = 1'b1;
        pat_in   = 4'b1101;
        bit_in(1'b1, 1'b0, 1'b0, "t4_load");
        pat_load = 1'b0;
        check_val("t4_load_count", {24'd0, match_count}, 32'd1);
        send(8'b0000_1101, 4, 8'b0000_0001, "t4b");
        send(8'b0000_1010, 4, 8'b0000_0000, "t4c");
        check_val("t4_count", {24'd0, match_count}, 32'd2);

        // 1111 overlapping on eight ones: hits on bits 4..8, 2-bit counter sticks at 3.
        do_reset();
        overlap_en = 1'b1;
        pat_load   = 1'b1;
        pat_in     = 4'b1111;
        bit_in(1'b0, 1'b0, 1'b0, "t5_load");
        pat_load = 1'b0;
        send(8'b1111_1111, 8, 8'b0001_1111, "t5");
        check_val("t5_count_sat", {30'd0, match_count_sat}, 32'd3);
        check_val("t5_count", {24'd0, match_count}, 32'd5);
        count_clr = 1'b1;
        bit_in(1'b1, 1'b1, 1'b1, "t5_clr_detect");
        count_clr = 1'b0;
        check_val("t5_clr_count_sat", {30'd0, match_count_sat}, 32'd0);
        check_val("t5_clr_count", {24'd0, match_count}, 32'd0);

        // Reset after 1,0,1 with a completing 0 on the wire: no detect, pattern back to 1010.
        do_reset();
        overlap_en = 1'b0;
        send(8'b0000_0101, 3, 8'b0000_0000, "t6a");
        reset = 1'b1;
        bit_in(1'b1, 1'b0, 1'b0, "t6_rst");
        reset = 1'b0;
        send(8'b0000_1010, 5, 8'b0000_0001, "t6b");
        check_val("t6_count", {24'd0, match_count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector, successor to the fixed 4-bit Mealy detector.
- Pattern length is set at build time. The pattern value can be loaded at run time.
- Overlapping or non-overlapping detection is selectable at run time.
- Input has a valid qualifier; a saturating match counter is provided. Sits on serial data paths as a frame-sync or marker detector.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..32.
- CNT_W, 8, width of match counter.
- PAT_RESET, 4'b1010 (PAT_LEN bits), pattern register value after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- din_valid  input  1  din carries a bit this cycle.
- din  input  1  serial data bit.
- pat_load  input  1  load pat_in into pattern register this cycle.
- pat_in  input  PAT_LEN  new pattern; MSB is the first bit received.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- count_clr  input  1  clear match_count.
- detect  output  1  Mealy match flag; combinational, valid in the cycle the final pattern bit is presented.
- match_count  output  CNT_W  number of detections, saturating.

Behaviour:
- Registered state:
  - pat_r[PAT_LEN-1:0]: pattern register.
  - hist[PAT_LEN-2:0]: last PAT_LEN-1 accepted bits; newest bit in LSB.
  - fill: count of accepted bits since the last flush, saturating at PAT_LEN-1.
  - match_count.
- Reset (synchronous): pat_r=PAT_RESET, hist=0, fill=0, match_count=0. detect is forced 0 in any cycle where reset=1.
- Accepted bit: a cycle with din_valid=1, pat_load=0, reset=0.
- Match condition, evaluated combinationally: accepted bit AND fill==PAT_LEN-1 AND {hist,din}==pat_r. detect=1 when true, else 0. There is no registered latency; this is the same timing as the original Mealy block.
- Update on an accepted bit with no match: hist={hist[PAT_LEN-3:0],din} (for PAT_LEN=2: hist=din); fill=min(fill+1,PAT_LEN-1).
- Update on an accepted bit with a match:
  - overlap_en=1: hist shifts as above; fill stays PAT_LEN-1. The next match can reuse the suffix bits.
  - overlap_en=0: hist=0, fill=0. The next match needs PAT_LEN fresh bits. This reproduces the non-overlapping behaviour of the original 1010 detector.
- din_valid=0: hist, fill and detect hold/0. Gaps do not break a partial match.
- overlap_en is sampled in the match cycle only. Changing it mid-stream affects the next match only.
- pat_load=1: pat_r=pat_in, hist=0, fill=0, detect=0. A din bit presented in the same cycle is discarded. match_count is unaffected.
- match_count:
  - Increments by 1 on each detect.
  - Saturates at all-ones; no wrap.
  - count_clr=1 sets it to 0. count_clr dominates a simultaneous detect, so the result is 0.
- Priority, highest first: reset > pat_load > accepted bit. count_clr is independent of pat_load.
- Reset mid-pattern discards the partial match. Detection restarts with PAT_RESET.
- Bit order: the first bit of the sequence matches pat_r[PAT_LEN-1], the last matches pat_r[0].

Test Plan:
- Reset, PAT_LEN=4, overlap_en=0, accepted bits 1,0,1,0,1,0 -> detect=1 on bit 4 only; match_count=1.
- Same stream with overlap_en=1 -> detect=1 on bits 4 and 6; match_count=2.
- Bits 1,0, then din_valid=0 for 3 cycles, then 1,0 -> detect=1 on the final 0; no detect during the gap.
- pat_load with pat_in=4'b1101 while din_valid=1 (din discarded), then bits 1,1,0,1 -> detect on bit 4. Then send 1,0,1,0 -> no detect.
- CNT_W=2, overlap_en=1, pattern 1111, stream of 8 ones -> detects on bits 4..8; match_count saturates at 3. Asserting count_clr during a detect cycle gives match_count=0.
- Assert reset after bits 1,0,1, then send 0 -> detect=0. Then send 1,0,1,0 -> detect on the last bit.
